program_loader: RTL and testbench

- Writer side of the Tinker instruction memory.
- Accepts a byte stream over a valid/ready handshake and packs bytes little-endian into 64-bit words. Writes each word through the memory's 8-byte write port, starting at the reset PC 0x2000.
- Holds the core in reset until the image is fully written, then releases it so fetch begins at 0x2000.

---
 rtl/tinker_pkg.sv | 24 ++
 rtl/program_loader_if.sv | 25 ++
 rtl/program_loader_byte_packer.sv | 35 +++
 rtl/program_loader.sv | 178 +++++++++++++++++
 tb/tb_program_loader.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tinker_pkg.sv
// Shared definitions for the Tinker instruction-memory loader.
//   RESET_PC       : core reset PC, also the loader's first write address
//   WORD_BYTES     : bytes per instruction-memory write word
//   loader_state_e : program loader FSM states
//   word_addr()    : byte address of a given word index from a base
package tinker_pkg;

    localparam logic [63:0] RESET_PC   = 64'h0000_0000_0000_2000;
    localparam int unsigned WORD_BYTES = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } loader_state_e;

    // Address of word idx; wraps modulo 2^64.
    function automatic logic [63:0] word_addr(input logic [63:0] base, input logic [63:0] idx);
        return base + (idx * 64'(WORD_BYTES));
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input handshake and 8-byte memory write port of the loader.
//   in_valid/in_data/in_last/in_ready : byte stream, valid/ready
//   mem_wr_en/mem_addr/mem_wr_data    : 8-byte write strobe, address, data
// master = stream source / memory side, slave = the loader.
interface program_loader_if;

    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic        mem_wr_en;
    logic [63:0] mem_addr;
    logic [63:0] mem_wr_data;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, mem_wr_en, mem_addr, mem_wr_data
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, mem_wr_en, mem_addr, mem_wr_data
    );

endinterface

// File: rtl/program_loader_byte_packer.sv
// Lane-indexed 8x8 byte register that assembles one 64-bit word.
//   clk, reset : clock, async active-high reset
//   clear      : zero all lanes (wins over wr_en)
//   wr_en      : store data_byte into lane
//   lane       : byte lane 0..7, lane k occupies bits [8k+7:8k]
//   data_byte  : byte to store
//   word       : assembled word
module byte_packer
    import tinker_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        wr_en,
    input  logic [2:0]  lane,
    input  logic [7:0]  data_byte,
    output logic [63:0] word
);

    logic [63:0] word_r;

    // Lane storage: clear has priority over a byte write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_r <= 64'd0;
        end else if (clear) begin
            word_r <= 64'd0;
        end else if (wr_en) begin
            word_r[{lane, 3'b000} +: 8] <= data_byte;
        end
    end

    assign word = word_r;

endmodule

// File: rtl/program_loader.sv
// Writer side of the Tinker instruction memory. Packs a byte stream
// little-endian into 64-bit words, writes them from BASE_ADDR upward and
// holds the core in reset until the whole image has been written.
//   clk, reset   : clock, async active-high reset
//   start        : one-cycle pulse, begins a load from IDLE/DONE/ERROR
//   bus          : byte stream in, 8-byte memory write port out
//   core_reset   : core reset, low only in DONE
//   busy         : loading (RECV or WRITE)
//   done         : image written and core released
//   error        : sticky overflow / misaligned-image flag
//   bytes_loaded : bytes accepted in the current load
module program_loader
    import tinker_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = RESET_PC,
    parameter int unsigned MAX_BYTES = 4096,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    program_loader_if.slave  bus,
    output logic             core_reset,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] bytes_loaded
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

    loader_state_e    state_r;
    logic [CNT_W-1:0] bytes_r;
    logic [CNT_W-1:0] word_idx_r;
    logic             last_seen_r;
    logic             misalign_r;
    logic             wr_en_r;
    logic [63:0]      addr_r;
    logic [63:0]      wdata_r;
    logic             core_reset_r;
    logic             busy_r;
    logic             done_r;
    logic             error_r;

    logic             ready_s;
    logic             accept_s;
    logic             overflow_s;
    logic             start_ok_s;
    logic             pk_clear_s;
    logic [2:0]       lane_s;
    logic [63:0]      pack_word_s;
    logic [63:0]      merged_s;

    assign lane_s = bytes_r[2:0];

    // Handshake decode: ready comes straight from state and count so a full
    // image refuses the next byte in the very cycle it is offered
    always_comb begin
        ready_s    = 1'b0;
        overflow_s = 1'b0;
        start_ok_s = 1'b0;
        if (state_r == ST_RECV) begin
            ready_s    = (bytes_r != MAX_CNT);
            overflow_s = bus.in_valid && (bytes_r == MAX_CNT);
        end else begin
            ready_s    = 1'b0;
            overflow_s = 1'b0;
        end
        if ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERROR)) begin
            start_ok_s = start;
        end else begin
            start_ok_s = 1'b0;
        end
        accept_s   = bus.in_valid && ready_s;
        pk_clear_s = start_ok_s || (state_r == ST_WRITE);
    end

    // The byte accepted on the word-closing edge is not yet in the packer,
    // so the registered write data is the packer word with it merged in
    always_comb begin
        merged_s = pack_word_s;
        merged_s[{lane_s, 3'b000} +: 8] = bus.in_data;
    end

    byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (pk_clear_s),
        .wr_en     (accept_s),
        .lane      (lane_s),
        .data_byte (bus.in_data),
        .word      (pack_word_s)
    );

    // Loader FSM with counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            bytes_r      <= '0;
            word_idx_r   <= '0;
            last_seen_r  <= 1'b0;
            misalign_r   <= 1'b0;
            wr_en_r      <= 1'b0;
            addr_r       <= BASE_ADDR;
            wdata_r      <= 64'd0;
            core_reset_r <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            wr_en_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start_ok_s) begin
                        state_r      <= ST_RECV;
                        bytes_r      <= '0;
                        word_idx_r   <= '0;
                        last_seen_r  <= 1'b0;
                        misalign_r   <= 1'b0;
                        core_reset_r <= 1'b1;
                        busy_r       <= 1'b1;
                        done_r       <= 1'b0;
                        error_r      <= 1'b0;
                    end
                end
                ST_RECV: begin
                    if (overflow_s) begin
                        state_r      <= ST_ERROR;
                        busy_r       <= 1'b0;
                        error_r      <= 1'b1;
                        core_reset_r <= 1'b1;
                    end else if (accept_s) begin
                        bytes_r <= bytes_r + CNT_W'(1);
                        if ((lane_s == 3'd7) || bus.in_last) begin
                            state_r     <= ST_WRITE;
                            wr_en_r     <= 1'b1;
                            addr_r      <= word_addr(BASE_ADDR, 64'(word_idx_r));
                            wdata_r     <= merged_s;
                            last_seen_r <= bus.in_last;
                            // Image length must be a multiple of 4 bytes
                            misalign_r  <= bus.in_last && (bytes_r[1:0] != 2'b11);
                        end
                    end
                end
                ST_WRITE: begin
                    word_idx_r <= word_idx_r + CNT_W'(1);
                    if (last_seen_r && misalign_r) begin
                        state_r      <= ST_ERROR;
                        busy_r       <= 1'b0;
                        error_r      <= 1'b1;
                        core_reset_r <= 1'b1;
                    end else if (last_seen_r) begin
                        state_r      <= ST_DONE;
                        busy_r       <= 1'b0;
                        done_r       <= 1'b1;
                        core_reset_r <= 1'b0;
                    end else begin
                        state_r <= ST_RECV;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = ready_s;
    assign bus.mem_wr_en   = wr_en_r;
    assign bus.mem_addr    = addr_r;
    assign bus.mem_wr_data = wdata_r;
    assign core_reset      = core_reset_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign error           = error_r;
    assign bytes_loaded    = bytes_r;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader (MAX_BYTES=16 so overflow is reachable).
module tb_program_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        core_reset;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] bytes_loaded;

    program_loader_if bus ();

    program_loader #(
        .BASE_ADDR (64'h0000_0000_0000_2000),
        .MAX_BYTES (16),
        .CNT_W     (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .core_reset   (core_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .bytes_loaded (bytes_loaded)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wr_count = 0;
    int last_wr_cyc   = 0;
    int first_acc_cyc = 0;
    logic [127:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cycle counter for latency checks
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [63:0] addr, input logic [63:0] data);
        exp_q.push_back({addr, data});
    endtask

    // Monitor: every write strobe is popped against the scoreboard
    always @(negedge clk) begin
        logic [127:0] e;
        if (!reset && bus.mem_wr_en) begin
            wr_count++;
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write",
                         bus.mem_addr, bus.mem_wr_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", bus.mem_addr, e[127:64]);
                check("wr_data", bus.mem_wr_data, e[63:0]);
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},   64'(bus.in_ready), 64'd0);
        check({tag, "_mem_wr_en"},  64'(bus.mem_wr_en), 64'd0);
        check({tag, "_mem_addr"},   bus.mem_addr, 64'h2000);
        check({tag, "_mem_wr_data"}, bus.mem_wr_data, 64'd0);
        check({tag, "_core_reset"}, 64'(core_reset), 64'd1);
        check({tag, "_busy"},       64'(busy), 64'd0);
        check({tag, "_done"},       64'(done), 64'd0);
        check({tag, "_error"},      64'(error), 64'd0);
        check({tag, "_bytes"},      64'(bytes_loaded), 64'd0);
    endtask

    // Called #1 after a posedge; returns #1 after the posedge of the pulse
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offer n bytes first, first+1, ...; returns #1 after the last accept
    task automatic send(input logic [7:0] first, input int n, input bit with_last, input bit gaps);
        int i;
        int guard;
        bit acc;
        i = 0;
        guard = 0;
        while ((i < n) && (guard < 400)) begin
            if (gaps && ($urandom_range(0, 1) == 0)) begin
                bus.in_valid = 1'b0;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = first + 8'(i);
                bus.in_last  = with_last && (i == n - 1);
            end
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (acc && (i == 0)) first_acc_cyc = cyc;
            @(posedge clk); #1;
            if (acc) i++;
            guard++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (i < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got %0d bytes accepted expected %0d", i, n);
        end
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        bus.in_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst");
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: one aligned word
        pulse_start();
        wr_count = 0;
        expect_wr(64'h2000, 64'h0706_0504_0302_0100);
        send(8'h00, 8, 1'b1, 1'b0);
        @(negedge clk);
        check("t1_busy_in_write", 64'(busy), 64'd1);
        check("t1_done_in_write", 64'(done), 64'd0);
        @(negedge clk);
        check("t1_done", 64'(done), 64'd1);
        check("t1_core_reset", 64'(core_reset), 64'd0);
        check("t1_busy", 64'(busy), 64'd0);
        check("t1_bytes", 64'(bytes_loaded), 64'd8);
        check("t1_writes", 64'(wr_count), 64'd1);
        check("t1_latency", 64'(last_wr_cyc - first_acc_cyc), 64'd8);
        @(posedge clk); #1;

        // 2: 12 bytes, restart from DONE
        pulse_start();
        @(negedge clk);
        check("t2_core_reset_restart", 64'(core_reset), 64'd1);
        check("t2_done_restart", 64'(done), 64'd0);
        check("t2_bytes_cleared", 64'(bytes_loaded), 64'd0);
        check("t2_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        wr_count = 0;
        expect_wr(64'h2000, 64'h1716_1514_1312_1110);
        expect_wr(64'h2008, 64'h0000_0000_1B1A_1918);
        send(8'h10, 12, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("t2_done", 64'(done), 64'd1);
        check("t2_error", 64'(error), 64'd0);
        check("t2_writes", 64'(wr_count), 64'd2);
        check("t2_bytes", 64'(bytes_loaded), 64'd12);
        @(posedge clk); #1;

        // 3: 16 bytes with random in_valid gaps
        pulse_start();
        wr_count = 0;
        expect_wr(64'h2000, 64'h2726_2524_2322_2120);
        expect_wr(64'h2008, 64'h2F2E_2D2C_2B2A_2928);
        send(8'h20, 16, 1'b1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("t3_done", 64'(done), 64'd1);
        check("t3_writes", 64'(wr_count), 64'd2);
        check("t3_bytes", 64'(bytes_loaded), 64'd16);
        @(posedge clk); #1;

        // 4: misaligned 6-byte image
        pulse_start();
        wr_count = 0;
        expect_wr(64'h2000, 64'h0000_3534_3332_3130);
        send(8'h30, 6, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("t4_error", 64'(error), 64'd1);
        check("t4_core_reset", 64'(core_reset), 64'd1);
        check("t4_done", 64'(done), 64'd0);
        check("t4_in_ready", 64'(bus.in_ready), 64'd0);
        check("t4_writes", 64'(wr_count), 64'd1);
        @(posedge clk); #1;
        pulse_start();
        @(negedge clk);
        check("t4_error_cleared", 64'(error), 64'd0);
        check("t4_ready_after_start", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;

        // 5: overflow, 17th byte refused
        wr_count = 0;
        expect_wr(64'h2000, 64'h4746_4544_4342_4140);
        expect_wr(64'h2008, 64'h4F4E_4D4C_4B4A_4948);
        send(8'h40, 16, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h50;
        bus.in_last  = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("t5_17th_ready", 64'(bus.in_ready), 64'd0);
        check("t5_bytes_full", 64'(bytes_loaded), 64'd16);
        @(posedge clk); #1;
        @(negedge clk);
        check("t5_error", 64'(error), 64'd1);
        check("t5_core_reset", 64'(core_reset), 64'd1);
        check("t5_writes", 64'(wr_count), 64'd2);
        check("t5_bytes", 64'(bytes_loaded), 64'd16);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;

        // 6: async reset during the 5th byte, then reload
        pulse_start();
        send(8'h60, 4, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h64;
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("midrst");
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        pulse_start();
        wr_count = 0;
        expect_wr(64'h2000, 64'h6766_6564_6362_6160);
        send(8'h60, 8, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("t6_done", 64'(done), 64'd1);
        check("t6_writes", 64'(wr_count), 64'd1);
        @(posedge clk); #1;

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
